// File: rtl/riscv_pkg.sv
// Shared definitions for the R-type RV32I core: opcode, function fields,
// ALU operation codes and the sequencer state encoding.
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StWriteback,
    StHalt
  } seq_state_e;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Instruction-fetch handshake, run control and datapath control bundle.
// master: the sequencer; slave: instruction memory / datapath side.
interface multicycle_sequencer_if #(
  parameter int unsigned CNT_W = 32
) ();

  logic             run;
  logic             imem_req;
  logic             imem_valid;
  logic [31:0]      imem_rdata;
  logic [31:0]      ir;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd;
  logic [3:0]       alu_control;
  logic             regwrite;
  logic             pc_en;
  logic             busy;
  logic             halted;
  logic             illegal;
  logic             fetch_timeout;
  logic [CNT_W-1:0] retired_count;

  modport master (
    input  run, imem_valid, imem_rdata,
    output imem_req, ir, rs1, rs2, rd, alu_control, regwrite, pc_en, busy, halted,
           illegal, fetch_timeout, retired_count
  );

  modport slave (
    output run, imem_valid, imem_rdata,
    input  imem_req, ir, rs1, rs2, rd, alu_control, regwrite, pc_en, busy, halted,
           illegal, fetch_timeout, retired_count
  );

endinterface

// File: rtl/alu_decoder.sv
// Maps the R-type {funct7, funct3} pair to an ALU operation code and flags
// pairs the ALU does not implement. Purely combinational.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] funct7_i,
  input  logic [2:0] funct3_i,
  output logic [3:0] alu_control_o,
  output logic       supported_o
);

  // Decode the function fields; anything outside the supported set is flagged.
  always_comb begin
    alu_control_o = ALU_AND;
    supported_o   = 1'b0;
    case (funct7_i)
      F7_BASE: begin
        supported_o = 1'b1;
        case (funct3_i)
          F3_ADD_SUB: alu_control_o = ALU_ADD;
          F3_SLL:     alu_control_o = ALU_SLL;
          F3_SLT:     alu_control_o = ALU_SLT;
          F3_SLTU:    alu_control_o = ALU_SLTU;
          F3_XOR:     alu_control_o = ALU_XOR;
          F3_SRL_SRA: alu_control_o = ALU_SRL;
          F3_OR:      alu_control_o = ALU_OR;
          default:    alu_control_o = ALU_AND;
        endcase
      end
      F7_ALT: begin
        case (funct3_i)
          F3_ADD_SUB: begin
            alu_control_o = ALU_SUB;
            supported_o   = 1'b1;
          end
          F3_SRL_SRA: begin
            alu_control_o = ALU_SRA;
            supported_o   = 1'b1;
          end
          default: supported_o = 1'b0;
        endcase
      end
      default: supported_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Fetch/decode/execute/writeback sequencer for the R-type core, with run/halt
// control, an illegal-instruction trap, a fetch watchdog and a retire counter.
module multicycle_sequencer
  import riscv_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 16,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  multicycle_sequencer_if.master  bus
);

  localparam int unsigned WdW = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);
  // Value of the watchdog during the last FETCH cycle allowed before the trap.
  localparam logic [WdW-1:0] WdLast = WdW'(FETCH_TIMEOUT - 1);

  seq_state_e       state_q;
  logic [31:0]      ir_q;
  logic [3:0]       alu_control_q;
  logic             regwrite_q;
  logic             pc_en_q;
  logic             illegal_q;
  logic             fetch_timeout_q;
  logic [WdW-1:0]   wd_q;
  logic [CNT_W-1:0] retired_q;

  logic [3:0] dec_alu;
  logic       dec_supported;
  logic       dec_legal;

  alu_decoder u_alu_decoder (
    .funct7_i      (ir_q[31:25]),
    .funct3_i      (ir_q[14:12]),
    .alu_control_o (dec_alu),
    .supported_o   (dec_supported)
  );

  assign dec_legal = (ir_q[6:0] == OP_RTYPE) && dec_supported;

  // Sequencer FSM; strobes are registered one state early so they are high
  // exactly during WRITEBACK, and a reset before that edge suppresses them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      ir_q            <= '0;
      alu_control_q   <= '0;
      regwrite_q      <= 1'b0;
      pc_en_q         <= 1'b0;
      illegal_q       <= 1'b0;
      fetch_timeout_q <= 1'b0;
      wd_q            <= '0;
      retired_q       <= '0;
    end else begin
      regwrite_q <= 1'b0;
      pc_en_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.run) state_q <= StFetch;
        end
        StFetch: begin
          // A valid word on the expiry cycle takes priority over the trap.
          if (bus.imem_valid) begin
            ir_q    <= bus.imem_rdata;
            wd_q    <= '0;
            state_q <= StDecode;
          end else if (wd_q == WdLast) begin
            fetch_timeout_q <= 1'b1;
            wd_q            <= '0;
            state_q         <= StHalt;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        StDecode: begin
          if (dec_legal) begin
            alu_control_q <= dec_alu;
            state_q       <= StExecute;
          end else begin
            illegal_q <= 1'b1;
            state_q   <= StHalt;
          end
        end
        StExecute: begin
          // Writes to x0 retire normally but never strobe the register file.
          regwrite_q <= (ir_q[11:7] != 5'd0);
          pc_en_q    <= 1'b1;
          state_q    <= StWriteback;
        end
        StWriteback: begin
          retired_q <= retired_q + 1'b1;
          state_q   <= bus.run ? StFetch : StIdle;
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ir            = ir_q;
  assign bus.rs1           = ir_q[19:15];
  assign bus.rs2           = ir_q[24:20];
  assign bus.rd            = ir_q[11:7];
  assign bus.alu_control   = alu_control_q;
  assign bus.regwrite      = regwrite_q;
  assign bus.pc_en         = pc_en_q;
  assign bus.illegal       = illegal_q;
  assign bus.fetch_timeout = fetch_timeout_q;
  assign bus.retired_count = retired_q;
  assign bus.imem_req      = (state_q == StFetch);
  assign bus.halted        = (state_q == StHalt);
  assign bus.busy          = (state_q == StFetch) || (state_q == StDecode) ||
                             (state_q == StExecute) || (state_q == StWriteback);

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer that owns the fetch/decode/execute/writeback cadence of the R-type RV32I core. It requests instructions from instruction memory over a valid/request handshake and latches them into an instruction register. It decodes register fields and the ALU operation, and issues the one-cycle `regwrite` and PC-advance strobes the datapath needs. It sits between instruction memory and the datapath, replacing the free-running fetch path, and adds run/halt control, an illegal-instruction trap, a fetch watchdog and a retired-instruction counter.

## Interface
- `FETCH_TIMEOUT`, default 16: max cycles in FETCH waiting for `imem_valid` before trapping.
- `CNT_W`, default 32: width of `retired_count`.
- `clock  input  1`: single clock, all state on rising edge.
- `reset  input  1`: asynchronous, active-low reset.
- `run  input  1`: level enable. Leaves IDLE when high; checked again at end of each instruction.
- `imem_req  output  1`: instruction fetch request, held high throughout FETCH.
- `imem_valid  input  1`: `imem_rdata` valid this cycle. Sampled only in FETCH.
- `imem_rdata  input  32`: fetched instruction word.
- `ir  output  32`: instruction register.
- `rs1`, `rs2`, `rd  output  5 each`: `ir[19:15]`, `ir[24:20]`, `ir[11:7]`.
- `alu_control  output  4`: ALU operation, registered in DECODE.
- `regwrite  output  1`: one-cycle register-file write strobe.
- `pc_en  output  1`: one-cycle PC advance strobe (PC += 4 in datapath).
- `busy  output  1`: high in every state except IDLE and HALT.
- `halted  output  1`: high in HALT.
- `illegal  output  1`: sticky trap cause, unsupported instruction.
- `fetch_timeout  output  1`: sticky trap cause, watchdog expired.
- `retired_count  output  CNT_W`: instructions completed since reset.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- **IDLE**
  - `run` = 1 → FETCH. Otherwise stay.
- **FETCH**
  - `imem_req` = 1; the watchdog counter increments each cycle.
  - `imem_valid` = 1 → latch `imem_rdata` into `ir`, clear the watchdog, go to DECODE.
  - Watchdog reaches `FETCH_TIMEOUT` with no valid → set `fetch_timeout`, go to HALT.
  - `imem_valid` in the same cycle as expiry: the valid wins, no trap.
- **DECODE**
  - Opcode must be 0110011 and the {funct7, funct3} pair must be supported. Otherwise set `illegal` and go to HALT; `ir` holds the offending word.
  - Valid instruction → register `alu_control`, go to EXECUTE.
- **EXECUTE**
  - One cycle for the ALU to settle → WRITEBACK.
- **WRITEBACK**
  - `regwrite` = 1, except when `rd` = 0, where it stays 0.
  - `pc_en` = 1 and `retired_count` increments, including for `rd` = 0.
  - Next state: FETCH if `run` = 1, else IDLE. A `run` drop mid-instruction never aborts the instruction.
- **HALT**
  - Terminal. No strobes; `imem_req` = 0. Left only via `reset`.
- ALU mapping, {funct7, funct3} → code:
  - ADD 0000000/000 → 0010
  - SUB 0100000/000 → 0100
  - SLL 0000000/001 → 0011
  - SLT 0000000/010 → 0110
  - SLTU 0000000/011 → 1001
  - XOR 0000000/100 → 0111
  - SRL 0000000/101 → 0101
  - SRA 0100000/101 → 1000
  - OR 0000000/110 → 0001
  - AND 0000000/111 → 0000
- `retired_count` wraps modulo 2^CNT_W silently.

## Timing
- Reset values:
  - State IDLE.
  - `ir`, `alu_control` and `retired_count` all 0.
  - Every 1-bit output 0, including the watchdog and trap flags.
- Reset asserted mid-instruction aborts it immediately: no `regwrite` or `pc_en` is issued.
- All outputs are registered or decoded from state only; no input-to-output combinational path.
- Minimum 4 cycles per instruction when `imem_valid` is high on the first FETCH cycle. Each extra wait cycle adds one.
- `regwrite` and `pc_en` are coincident, exactly one cycle each per retired instruction.
- `illegal` and `fetch_timeout` assert in the cycle HALT is entered and hold until reset.

## Structure
- Shared package `riscv_pkg` holds:
  - opcode constant OP_RTYPE;
  - funct3/funct7 constants;
  - the 4-bit ALU code constants above;
  - the sequencer state enum.
- Combinational sub-module `alu_decoder` maps (funct7, funct3) → {alu_control, supported}. The Control unit reuses it.
- Everything else (FSM, watchdog, counter, instruction register) lives in `multicycle_sequencer`.

## Test plan
- Reset, `run`=1, `imem_valid` tied high, `imem_rdata`=0x002081B3 (add x3,x1,x2):
  - `alu_control`=0010, `rs1`=1, `rs2`=2, `rd`=3.
  - `regwrite` and `pc_en` pulse on cycle 4; `retired_count`=1.
- `imem_valid` delayed 3 cycles:
  - WRITEBACK occurs on cycle 7; `imem_req` stays high for 4 cycles.
- `imem_rdata`=0x00000013 (addi):
  - HALT, `illegal`=1, `regwrite` never pulses, `pc_en`=0, `ir`=0x00000013.
- `imem_valid` held low, `FETCH_TIMEOUT`=16:
  - `fetch_timeout`=1 and `halted`=1 after 16 FETCH cycles.
  - Repeat with valid arriving on the expiry cycle: no trap.
- `run` dropped during EXECUTE:
  - The instruction still retires, then IDLE with `busy`=0.
  - An instruction with `rd`=0 retires with `regwrite`=0 and `retired_count` incremented.
- `reset` asserted during WRITEBACK-1:
  - No strobe issued; all outputs return to reset values asynchronously.
